// File: rtl/poly_mult_seq_pkg.sv
// Shared types for the sequential polynomial multiplier: FSM encoding, reduction modes
// and the counter-width helper.
package poly_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic MODE_CYCLIC     = 1'b0;
  localparam logic MODE_NEGACYCLIC = 1'b1;

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/poly_mult_seq_if.sv
// Operand/result bundle of the polynomial multiplier.
// Handshake: a transfer happens on a rising edge where valid && ready; the sender holds
// its payload stable while valid is high and ready is low, and ready never waits on valid.
interface poly_mult_seq_if #(
  parameter int N = 4,
  parameter int W = 8
);
  logic           in_valid;
  logic           in_ready;
  logic           mode;
  logic [N*W-1:0] a_in;
  logic [N*W-1:0] b_in;
  logic           out_valid;
  logic           out_ready;
  logic [N*W-1:0] c_out;
  logic           busy;

  modport master (
    output in_valid, mode, a_in, b_in, out_ready,
    input  in_ready, out_valid, c_out, busy
  );

  modport slave (
    input  in_valid, mode, a_in, b_in, out_ready,
    output in_ready, out_valid, c_out, busy
  );
endinterface

// File: rtl/poly_mult_seq_mac.sv
// One coefficient multiply-accumulate step; wrapped terms are subtracted in negacyclic mode.
module poly_mac
  import poly_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] acc_word,
  input  logic         wrap,
  input  logic         mode,
  output logic [W-1:0] new_word
);
  logic [W-1:0] prod;

  // W-bit result keeps only the low half of the product, i.e. mod 2^W
  assign prod     = a * b;
  assign new_word = (wrap && (mode == MODE_NEGACYCLIC)) ? acc_word - prod : acc_word + prod;
endmodule

// File: rtl/poly_mult_seq.sv
// Sequential C = A*B mod (x^N -/+ 1): one coefficient MAC per cycle, j inner, i outer.
module poly_mult_seq
  import poly_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic            clk,
  input  logic            rst,
  poly_mult_seq_if.slave  bus,
  output state_t          state
);
  localparam int              IW    = idx_width(N);
  localparam logic [IW-1:0]   LAST  = IW'(N - 1);
  localparam logic [IW:0]     N_EXT = (IW + 1)'(N);

  logic [IW-1:0]        i_idx;
  logic [IW-1:0]        j_idx;
  logic [N-1:0][W-1:0]  a_reg;
  logic [N-1:0][W-1:0]  b_reg;
  logic [N-1:0][W-1:0]  acc;
  logic [N-1:0][W-1:0]  acc_next;
  logic [N-1:0][W-1:0]  c_reg;
  logic                 mode_reg;
  logic                 out_valid_reg;
  logic [IW:0]          sum;
  logic                 wrap;
  logic [IW-1:0]        k_idx;
  logic [W-1:0]         mac_word;

  assign sum   = {1'b0, i_idx} + {1'b0, j_idx};
  assign wrap  = (sum >= N_EXT);
  assign k_idx = wrap ? IW'(sum - N_EXT) : sum[IW-1:0];

  poly_mac #(.W(W)) u_mac (
    .a        (a_reg[i_idx]),
    .b        (b_reg[j_idx]),
    .acc_word (acc[k_idx]),
    .wrap     (wrap),
    .mode     (mode_reg),
    .new_word (mac_word)
  );

  // Accumulator image including the current term; feeds c_out on the last term
  always_comb begin
    acc_next        = acc;
    acc_next[k_idx] = mac_word;
  end

  assign bus.in_ready  = (state == S_IDLE) && !rst;
  assign bus.out_valid = out_valid_reg;
  assign bus.c_out     = c_reg;
  assign bus.busy      = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      i_idx         <= '0;
      j_idx         <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      acc           <= '0;
      c_reg         <= '0;
      mode_reg      <= MODE_CYCLIC;
      out_valid_reg <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            a_reg    <= bus.a_in;
            b_reg    <= bus.b_in;
            mode_reg <= bus.mode;
            acc      <= '0;
            i_idx    <= '0;
            j_idx    <= '0;
            state    <= S_MAC;
          end
        end
        S_MAC: begin
          acc <= acc_next;
          if (j_idx == LAST) begin
            j_idx <= '0;
            if (i_idx == LAST) begin
              c_reg         <= acc_next;
              out_valid_reg <= 1'b1;
              state         <= S_DONE;
            end else begin
              i_idx <= i_idx + IW'(1);
            end
          end else begin
            j_idx <= j_idx + IW'(1);
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            state         <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_poly_mult_seq.sv
// Self-checking bench for poly_mult_seq: directed vectors, handshake, mid-job reset,
// then random jobs compared against a fold-the-linear-product reference model.
module tb_poly_mult_seq;
  import poly_pkg::*;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int CW = N * W;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  state_t state;

  poly_mult_seq_if #(.N(N), .W(W)) bus ();

  poly_mult_seq #(.N(N), .W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus.slave),
    .state (state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  int checks = 0;
  int errors = 0;
  logic [CW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: full linear product, then fold the upper half back with +/- sign
  function automatic logic [CW-1:0] ref_mult(input logic [CW-1:0] a, input logic [CW-1:0] b,
                                             input logic m);
    int lin[2*N-1];
    int v;
    logic [CW-1:0] c;
    c = '0;
    for (int k = 0; k < 2*N-1; k++) lin[k] = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        lin[i+j] += int'(a[i*W +: W]) * int'(b[j*W +: W]);
    for (int k = 0; k < N; k++) begin
      v = lin[k];
      if (k + N < 2*N-1) v = m ? v - lin[k+N] : v + lin[k+N];
      c[k*W +: W] = W'(v);
    end
    return c;
  endfunction

  function automatic logic [CW-1:0] pack4(input int c0, input int c1, input int c2, input int c3);
    return {W'(c3), W'(c2), W'(c1), W'(c0)};
  endfunction

  // driver tasks
  task automatic start_job(input logic [CW-1:0] a, input logic [CW-1:0] b, input logic m,
                           input logic [CW-1:0] exp);
    int t = 0;
    while (!bus.in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("in_ready_wait", 64'(bus.in_ready), 64'd1);
    bus.a_in     = a;
    bus.b_in     = b;
    bus.mode     = m;
    bus.in_valid = 1'b1;
    exp_q.push_back(exp);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a_in     = CW'($urandom);
    bus.b_in     = CW'($urandom);
    bus.mode     = 1'($urandom);
  endtask

  task automatic finish_job(input string tag, input int lat0, input int hold);
    int lat = lat0;
    logic [CW-1:0] held;
    logic [CW-1:0] exp;
    while (!bus.out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(N*N));
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    check({tag, "_c"}, 64'(bus.c_out), 64'(exp));
    held = bus.c_out;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, 64'(bus.out_valid), 64'd1);
      check({tag, "_hold_c"}, 64'(bus.c_out), 64'(held));
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_post_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_post_ready"}, 64'(bus.in_ready), 64'd1);
    check({tag, "_post_busy"}, 64'(bus.busy), 64'd0);
    check({tag, "_post_c"}, 64'(bus.c_out), 64'(held));
  endtask

  task automatic run_job(input string tag, input logic [CW-1:0] a, input logic [CW-1:0] b,
                         input logic m, input logic [CW-1:0] exp, input int hold);
    start_job(a, b, m, exp);
    finish_job(tag, 0, hold);
  endtask

  logic [CW-1:0] va, vb, ra, rb;
  logic          rm;
  int            seen;

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.mode      = 1'b0;
    bus.a_in      = '0;
    bus.b_in      = '0;
    repeat (3) @(negedge clk);
    check("rst_state", 64'(state), 64'(S_IDLE));
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_c_out", 64'(bus.c_out), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 64'(bus.in_ready), 64'd1);

    va = pack4(1, 2, 3, 4);
    run_job("identity", va, pack4(1, 0, 0, 0), 1'b0, pack4(1, 2, 3, 4), 0);
    run_job("shift_cyc", va, pack4(0, 1, 0, 0), 1'b0, pack4(4, 1, 2, 3), 1);
    run_job("shift_neg", va, pack4(0, 1, 0, 0), 1'b1, pack4(252, 1, 2, 3), 0);
    vb = pack4(5, 6, 7, 8);
    run_job("full_cyc", va, vb, 1'b0, pack4(66, 68, 66, 60), 2);
    run_job("full_neg", va, vb, 1'b1, pack4(200, 220, 2, 60), 0);
    run_job("wrap16", pack4(16, 0, 0, 0), pack4(16, 0, 0, 0), 1'b0, pack4(0, 0, 0, 0), 0);
    run_job("wrap255", pack4(255, 0, 0, 0), pack4(255, 0, 0, 0), 1'b1, pack4(1, 0, 0, 0), 0);

    // in_valid while busy must be ignored; then 10 cycles of backpressure
    start_job(va, vb, 1'b1, pack4(200, 220, 2, 60));
    bus.in_valid = 1'b1;
    bus.a_in     = pack4(9, 9, 9, 9);
    for (int t = 0; t < 3; t++) begin
      check("busy_in_ready", 64'(bus.in_ready), 64'd0);
      check("busy_flag", 64'(bus.busy), 64'd1);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    finish_job("busy_ignore", 3, 10);

    // abort mid-job with reset
    start_job(va, vb, 1'b0, pack4(66, 68, 66, 60));
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    void'(exp_q.pop_back());
    check("abort_state", 64'(state), 64'(S_IDLE));
    check("abort_out_valid", 64'(bus.out_valid), 64'd0);
    check("abort_c_out", 64'(bus.c_out), 64'd0);
    check("abort_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("abort_no_result", 64'(seen), 64'd0);
    run_job("after_abort", va, vb, 1'b0, pack4(66, 68, 66, 60), 0);

    // random jobs with random backpressure
    for (int r = 0; r < 25; r++) begin
      ra = CW'($urandom);
      rb = CW'($urandom);
      rm = 1'($urandom_range(0, 1));
      run_job("rand", ra, rb, rm, ref_mult(ra, rb, rm), $urandom_range(0, 3));
    end

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
